alu_mod_seq: RTL and testbench

- Multi-cycle sequencer that computes unsigned A mod B (and the quotient) by driving the shared 8-bit ALU.
- ALU operations: 00 AND, 01 XOR, 10 ADD, 11 rotate-left.
- Forms -B as XOR(B, 0xFF) + 0x01, then subtracts repeatedly by ADD(r, -B) until the ADD carry shows r < B.
- Sits between the control/decode logic and the ALU; owns the ALU inputs while busy.

---
 rtl/alu_mod_seq_if.sv | 30 +++
 rtl/alu_mod_seq.sv | 148 ++++++++++++++
 tb/tb_alu_mod_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mod_seq_if.sv
// Bus between the control/decode side, the A mod B sequencer and the shared 8-bit ALU.
// master = control logic plus ALU; slave = the sequencer.
interface alu_mod_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] quotient;
    logic             div_zero;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_c0;
    logic             alu_z;

    modport master (
        output start, op_a, op_b, alu_out, alu_c0, alu_z,
        input  busy, done, result, quotient, div_zero, alu_a, alu_b, alu_sel
    );

    modport slave (
        input  start, op_a, op_b, alu_out, alu_c0, alu_z,
        output busy, done, result, quotient, div_zero, alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu_mod_seq.sv
// Multi-cycle unsigned A mod B / A div B sequencer that borrows the shared ALU:
// negates B once (XOR 0xFF, +1), then adds -B until the ADD carry reports r < B.
module alu_mod_seq #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mod_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_XOR = 2'b01,
        ALU_ADD = 2'b10,
        ALU_ROL = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_X,
        S_NEG_I,
        S_SUB,
        S_DONE
    } state_e;

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             div_zero_q, div_zero_d;

    alu_op_e          alu_sel_c;
    logic [WIDTH-1:0] alu_a_c;
    logic [WIDTH-1:0] alu_b_c;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        r_d        = r_q;
        b_d        = b_q;
        nb_d       = nb_q;
        result_d   = result_q;
        quotient_d = quotient_q;
        div_zero_d = div_zero_q;
        alu_sel_c  = ALU_AND;
        alu_a_c    = ZERO;
        alu_b_c    = ZERO;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    r_d        = bus.op_a;
                    b_d        = bus.op_b;
                    quotient_d = ZERO;
                    div_zero_d = 1'b0;
                    if (bus.op_b == ZERO) begin
                        div_zero_d = 1'b1;
                        result_d   = bus.op_a;
                        state_d    = S_DONE;
                    end else begin
                        state_d    = S_NEG_X;
                    end
                end
            end

            S_NEG_X: begin
                alu_sel_c = ALU_XOR;
                alu_a_c   = b_q;
                alu_b_c   = ALL_ONES;
                nb_d      = bus.alu_out;
                state_d   = S_NEG_I;
            end

            S_NEG_I: begin
                // The carry of ~B + 1 only matters for B == 0, which never reaches here.
                alu_sel_c = ALU_ADD;
                alu_a_c   = nb_q;
                alu_b_c   = ONE;
                nb_d      = bus.alu_out;
                state_d   = S_SUB;
            end

            S_SUB: begin
                // r + (256 - B) carries out exactly when r >= B.
                alu_sel_c = ALU_ADD;
                alu_a_c   = r_q;
                alu_b_c   = nb_q;
                if (bus.alu_c0) begin
                    r_d        = bus.alu_out;
                    quotient_d = quotient_q + ONE;
                    if ((EARLY_EXIT != 0) && bus.alu_z) begin
                        result_d = ZERO;
                        state_d  = S_DONE;
                    end
                end else begin
                    result_d = r_q;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            r_q        <= ZERO;
            b_q        <= ZERO;
            nb_q       <= ZERO;
            result_q   <= ZERO;
            quotient_q <= ZERO;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            b_q        <= b_d;
            nb_q       <= nb_d;
            result_q   <= result_d;
            quotient_q <= quotient_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.quotient = quotient_q;
    assign bus.div_zero = div_zero_q;
    assign bus.alu_sel  = alu_sel_c;
    assign bus.alu_a    = alu_a_c;
    assign bus.alu_b    = alu_b_c;

endmodule

// File: tb/tb_alu_mod_seq.sv
// Bench for alu_mod_seq: two instances (EARLY_EXIT 0 and 1) share stimulus, each with
// its own ALU model, checked every cycle against an arithmetic model of A div/mod B.
module tb_alu_mod_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mod_seq_if #(.WIDTH(8)) if_ne ();
    alu_mod_seq_if #(.WIDTH(8)) if_ee ();

    alu_mod_seq #(.WIDTH(8), .EARLY_EXIT(0)) u_ne (.clk(clk), .rst_n(rst_n), .bus(if_ne));
    alu_mod_seq #(.WIDTH(8), .EARLY_EXIT(1)) u_ee (.clk(clk), .rst_n(rst_n), .bus(if_ee));

    // Combinational 8-bit ALU: {zero, c0, out}
    function automatic logic [9:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] sel);
        logic [8:0] s;
        logic [7:0] o;
        logic       c;
        s = 9'd0;
        o = 8'd0;
        c = 1'b0;
        case (sel)
            2'b00: o = a & b;
            2'b01: o = a ^ b;
            2'b10: begin
                s = {1'b0, a} + {1'b0, b};
                o = s[7:0];
                c = s[8];
            end
            default: begin
                o = {a[6:0], a[7]};
                c = a[7];
            end
        endcase
        return {(o == 8'd0), c, o};
    endfunction

    assign if_ne.start = start;
    assign if_ne.op_a  = op_a;
    assign if_ne.op_b  = op_b;
    assign if_ee.start = start;
    assign if_ee.op_a  = op_a;
    assign if_ee.op_b  = op_b;
    assign {if_ne.alu_z, if_ne.alu_c0, if_ne.alu_out} = alu(if_ne.alu_a, if_ne.alu_b, if_ne.alu_sel);
    assign {if_ee.alu_z, if_ee.alu_c0, if_ee.alu_out} = alu(if_ee.alu_a, if_ee.alu_b, if_ee.alu_sel);

    // Index 0 = EARLY_EXIT 0, index 1 = EARLY_EXIT 1
    logic [1:0] busy_w, done_w, dz_w;
    logic [7:0] res_w [2];
    logic [7:0] q_w   [2];
    logic [7:0] a_w   [2];
    logic [7:0] b_w   [2];
    logic [1:0] sel_w [2];
    assign busy_w   = {if_ee.busy, if_ne.busy};
    assign done_w   = {if_ee.done, if_ne.done};
    assign dz_w     = {if_ee.div_zero, if_ne.div_zero};
    assign res_w[0] = if_ne.result;
    assign res_w[1] = if_ee.result;
    assign q_w[0]   = if_ne.quotient;
    assign q_w[1]   = if_ee.quotient;
    assign a_w[0]   = if_ne.alu_a;
    assign a_w[1]   = if_ee.alu_a;
    assign b_w[0]   = if_ne.alu_b;
    assign b_w[1]   = if_ee.alu_b;
    assign sel_w[0] = if_ne.alu_sel;
    assign sel_w[1] = if_ee.alu_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int exp_lat(input int a, input int b, input bit ee);
        if (b == 0) return 1;
        if (ee && (a % b == 0) && (a / b >= 1)) return a / b + 3;
        return a / b + 4;
    endfunction

    string nm [2] = '{"ne", "ee"};
    int    cyc = 0;
    bit    active  [2] = '{1'b0, 1'b0};
    int    t0      [2] = '{0, 0};
    int    lat     [2] = '{0, 0};
    int    ea      [2] = '{0, 0};
    int    eb      [2] = '{0, 0};
    int    exp_res [2] = '{0, 0};
    int    exp_q   [2] = '{0, 0};
    bit    exp_dz  [2] = '{1'b0, 1'b0};
    int    done_at [2] = '{-1, -1};

    function automatic int age(input int k);
        return cyc - t0[k];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                active[k]  <= 1'b0;
                exp_res[k] <= 0;
                exp_q[k]   <= 0;
                exp_dz[k]  <= 1'b0;
            end else if (active[k]) begin
                if (age(k) == lat[k]) active[k] <= 1'b0;
            end else if (start) begin
                active[k]  <= 1'b1;
                t0[k]      <= cyc;
                ea[k]      <= int'(op_a);
                eb[k]      <= int'(op_b);
                lat[k]     <= exp_lat(int'(op_a), int'(op_b), k == 1);
                exp_res[k] <= (op_b == 8'd0) ? int'(op_a) : int'(op_a) % int'(op_b);
                exp_q[k]   <= (op_b == 8'd0) ? 0 : int'(op_a) / int'(op_b);
                exp_dz[k]  <= (op_b == 8'd0);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!active[k]) begin
                check({nm[k], " idle busy"},   32'(busy_w[k]), 32'd0);
                check({nm[k], " idle done"},   32'(done_w[k]), 32'd0);
                check({nm[k], " held result"}, 32'(res_w[k]),  exp_res[k]);
                check({nm[k], " held quot"},   32'(q_w[k]),    exp_q[k]);
                check({nm[k], " held dz"},     32'(dz_w[k]),   32'(exp_dz[k]));
                check({nm[k], " idle sel"},    32'(sel_w[k]),  32'd0);
                check({nm[k], " idle alu_a"},  32'(a_w[k]),    32'd0);
                check({nm[k], " idle alu_b"},  32'(b_w[k]),    32'd0);
            end else begin
                check({nm[k], " busy"}, 32'(busy_w[k]), 32'd1);
                check({nm[k], " done"}, 32'(done_w[k]), 32'(age(k) == lat[k]));
                if (age(k) == 1) done_at[k] <= -1;
                if (done_w[k]) done_at[k] <= age(k);
                if (age(k) == lat[k]) begin
                    check({nm[k], " result"},   32'(res_w[k]), exp_res[k]);
                    check({nm[k], " quotient"}, 32'(q_w[k]),   exp_q[k]);
                    check({nm[k], " div_zero"}, 32'(dz_w[k]),  32'(exp_dz[k]));
                end else if (age(k) == 1) begin
                    check({nm[k], " negx sel"},   32'(sel_w[k]), 32'd1);
                    check({nm[k], " negx alu_a"}, 32'(a_w[k]),   eb[k]);
                    check({nm[k], " negx alu_b"}, 32'(b_w[k]),   32'hFF);
                end else if (age(k) == 2) begin
                    check({nm[k], " negi sel"},   32'(sel_w[k]), 32'd2);
                    check({nm[k], " negi alu_a"}, 32'(a_w[k]),   255 - eb[k]);
                    check({nm[k], " negi alu_b"}, 32'(b_w[k]),   32'd1);
                end else begin
                    check({nm[k], " sub sel"},   32'(sel_w[k]), 32'd2);
                    check({nm[k], " sub alu_a"}, 32'(a_w[k]),   ea[k] - (age(k) - 3) * eb[k]);
                    check({nm[k], " sub alu_b"}, 32'(b_w[k]),   256 - eb[k]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!active[0] && !active[1]) break;
            @(negedge clk);
        end
        check("idle timeout", 32'({active[1], active[0]}), 32'd0);
        @(negedge clk);
    endtask

    task automatic pin(input int k, input int res, input int q, input int dz, input int at);
        check({nm[k], " pin result"},   32'(res_w[k]), res);
        check({nm[k], " pin quotient"}, 32'(q_w[k]),   q);
        check({nm[k], " pin div_zero"}, 32'(dz_w[k]),  dz);
        check({nm[k], " pin latency"},  done_at[k],    at);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset busy",     32'(if_ne.busy),     32'd0);
        check("reset done",     32'(if_ee.done),     32'd0);
        check("reset result",   32'(if_ne.result),   32'd0);
        check("reset quotient", 32'(if_ee.quotient), 32'd0);
        check("reset div_zero", 32'(if_ne.div_zero), 32'd0);

        // 200 / 7 = 28 r 4
        launch(8'd200, 8'd7);   wait_idle();
        pin(0, 4, 28, 0, 32);   pin(1, 4, 28, 0, 32);

        // 12 / 4: early exit saves one cycle
        launch(8'd12, 8'd4);    wait_idle();
        pin(0, 0, 3, 0, 7);     pin(1, 0, 3, 0, 6);

        // A < B and A == 0
        launch(8'd5, 8'd9);     wait_idle();
        pin(0, 5, 0, 0, 4);     pin(1, 5, 0, 0, 4);
        launch(8'd0, 8'd3);     wait_idle();
        pin(0, 0, 0, 0, 4);     pin(1, 0, 0, 0, 4);

        // divide by zero, then a normal op clears div_zero
        launch(8'h5A, 8'd0);    wait_idle();
        pin(0, 'h5A, 0, 1, 1);  pin(1, 'h5A, 0, 1, 1);
        launch(8'd9, 8'd2);     wait_idle();
        pin(0, 1, 4, 0, 8);     pin(1, 1, 4, 0, 8);

        // worst case and B == A
        launch(8'd255, 8'd1);   wait_idle();
        pin(0, 0, 255, 0, 259); pin(1, 0, 255, 0, 258);
        launch(8'd255, 8'd255); wait_idle();
        pin(0, 0, 1, 0, 5);     pin(1, 0, 1, 0, 4);

        // start pulsed while busy is ignored
        launch(8'd200, 8'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op_a = 8'd3; op_b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        pin(0, 4, 28, 0, 32);   pin(1, 4, 28, 0, 32);

        // reset for one edge during SUB aborts without done
        launch(8'd200, 8'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy",     32'(if_ne.busy),     32'd0);
        check("abort done",     32'(if_ee.done),     32'd0);
        check("abort result",   32'(if_ee.result),   32'd0);
        check("abort quotient", 32'(if_ne.quotient), 32'd0);
        launch(8'd9, 8'd2);     wait_idle();
        pin(0, 1, 4, 0, 8);     pin(1, 1, 4, 0, 8);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
